// File: rtl/node_mem_arbiter.sv
// node_mem_arbiter: round-robin arbiter that shares the single read/write
//   port of the 32 x 12-bit node memory between the tree builder (req0)
//   and the tree walker (req1).
// Latency: req sampled in IDLE at cycle N, memory accessed in N+1, ack in
//   N+2; one transaction per 3 cycles.
// Backpressure: req/ack handshake; a requester holds req and its operands
//   until ack, and a losing requester simply waits in IDLE for its turn.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   reqN/weN/addrN/wdataN requester N transaction (N = 0, 1)
//   ackN/rdataN           one-cycle completion pulse and prior node contents
//   mem_*                 memory port; read data is combinational, write
//                         commits at the clock edge ending the ACCESS cycle
//
// Optional build macro NODE_MEM_ARB_LOCK_EN adds lock0/lock1 inputs. A grant
// taken with its lock high pins arbitration to that requester until one of
// its transactions is granted with lock low (or reset).

module node_mem_arbiter #(
  parameter int NODE_W = 12,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [NODE_W-1:0] wdata0,
  output logic              ack0,
  output logic [NODE_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [NODE_W-1:0] wdata1,
  output logic              ack1,
  output logic [NODE_W-1:0] rdata1,
`ifdef NODE_MEM_ARB_LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  output logic [ADDR_W-1:0] mem_read_addr,
  input  logic [NODE_W-1:0] mem_read_node,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [NODE_W-1:0] mem_write_node,
  output logic              mem_write
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              state_q;
  logic                gnt_q;         // requester owning the current transaction
  logic                last_grant_q;  // requester granted most recently
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [NODE_W-1:0]   wdata_q;
  logic                ack0_q;
  logic                ack1_q;
  logic [NODE_W-1:0]   rdata0_q;
  logic [NODE_W-1:0]   rdata1_q;

  // Arbitration result and operands of the winner, valid in IDLE.
  logic                grant_vld_d;
  logic                grant_id_d;
  logic                we_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [NODE_W-1:0]   wdata_d;

`ifdef NODE_MEM_ARB_LOCK_EN
  logic                locked_q;
  logic                lock_owner_q;
  logic                lock_d;
`endif

  always_comb begin
    grant_vld_d = req0 | req1;
    // Under contention the requester that did not win last time goes next.
    grant_id_d  = (req0 & req1) ? ~last_grant_q : req1;
`ifdef NODE_MEM_ARB_LOCK_EN
    // While locked only the owner can be granted; the other side waits.
    if (locked_q) begin
      grant_vld_d = lock_owner_q ? req1 : req0;
      grant_id_d  = lock_owner_q;
    end
    lock_d = grant_id_d ? lock1 : lock0;
`endif
    we_d    = grant_id_d ? we1    : we0;
    addr_d  = grant_id_d ? addr1  : addr0;
    wdata_d = grant_id_d ? wdata1 : wdata0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
`ifdef NODE_MEM_ARB_LOCK_EN
      locked_q     <= 1'b0;
      lock_owner_q <= 1'b0;
`endif
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_vld_d) begin
            gnt_q        <= grant_id_d;
            last_grant_q <= grant_id_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
`ifdef NODE_MEM_ARB_LOCK_EN
            // Lock state only matters at the next IDLE grant, so updating it
            // here behaves the same as updating it after RESP. A grant while
            // locked always belongs to the owner, so lock low releases it.
            if (lock_d) begin
              locked_q     <= 1'b1;
              lock_owner_q <= grant_id_d;
            end else begin
              locked_q     <= 1'b0;
            end
`endif
            state_q      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Read data is sampled at the same edge that commits the write,
          // so the requester always sees the node's prior contents.
          if (gnt_q) begin
            rdata1_q <= mem_read_node;
            ack1_q   <= 1'b1;
          end else begin
            rdata0_q <= mem_read_node;
            ack0_q   <= 1'b1;
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

  assign mem_read_addr  = addr_q;
  assign mem_write_addr = addr_q;
  assign mem_write_node = wdata_q;
  // Gated by reset so a transaction aborted in its ACCESS cycle never writes.
  assign mem_write      = (state_q == ST_ACCESS) & we_q & ~reset;

endmodule

// File: tb/tb_node_mem_arbiter.sv
module tb_node_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [4:0]  addr0, addr1;
  logic [11:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [11:0] rdata0, rdata1;
  logic [4:0]  mem_read_addr, mem_write_addr;
  logic [11:0] mem_read_node, mem_write_node;
  logic        mem_write;
`ifdef NODE_MEM_ARB_LOCK_EN
  logic        lock0, lock1;
`endif

  always #5 clk = ~clk;

  node_mem_arbiter #(.NODE_W(12), .ADDR_W(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .req0           (req0),
    .we0            (we0),
    .addr0          (addr0),
    .wdata0         (wdata0),
    .ack0           (ack0),
    .rdata0         (rdata0),
    .req1           (req1),
    .we1            (we1),
    .addr1          (addr1),
    .wdata1         (wdata1),
    .ack1           (ack1),
    .rdata1         (rdata1),
`ifdef NODE_MEM_ARB_LOCK_EN
    .lock0          (lock0),
    .lock1          (lock1),
`endif
    .mem_read_addr  (mem_read_addr),
    .mem_read_node  (mem_read_node),
    .mem_write_addr (mem_write_addr),
    .mem_write_node (mem_write_node),
    .mem_write      (mem_write)
  );

  // Node memory: combinational read, write at the clock edge.
  logic [11:0] salt;
  logic        mem_clear;
  logic [11:0] mem [32];

  function automatic logic [11:0] init_pattern(input int i, input logic [11:0] s);
    return 12'(i * 37) ^ s;
  endfunction

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_pattern(i, salt);
    end else if (mem_write) begin
      mem[mem_write_addr] <= mem_write_node;
    end
  end
  assign mem_read_node = mem[mem_read_addr];

  // Reference model: node contents, last winner, and each requester's rdata.
  logic [11:0] ref_mem [32];
  bit          m_last;
  logic [11:0] m_rd [2];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    m_last = 1'b1;
    m_rd[0] = '0;
    m_rd[1] = '0;
  endtask

  // One arbitration episode from IDLE: one or both requesters raise req
  // together; each drops its req on seeing its ack.
  task automatic episode(input bit u0, input bit u1,
                         input bit w0, input logic [4:0] a0, input logic [11:0] d0,
                         input bit w1, input logic [4:0] a1, input logic [11:0] d1);
    int          n;
    bit          ord [2];
    bit          wes [2];
    logic [4:0]  adr [2];
    logic [11:0] dat [2];
    logic [11:0] exp_rd [2];
    if (u0 && u1) begin
      ord[0] = !m_last; ord[1] = m_last; n = 2;
    end else begin
      ord[0] = u1; ord[1] = u1; n = 1;
    end
    for (int k = 0; k < n; k++) begin
      wes[k] = ord[k] ? w1 : w0;
      adr[k] = ord[k] ? a1 : a0;
      dat[k] = ord[k] ? d1 : d0;
      exp_rd[k] = ref_mem[adr[k]];
      if (wes[k]) ref_mem[adr[k]] = dat[k];
      m_last = ord[k];
    end
    req0 = u0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = u1; we1 = w1; addr1 = a1; wdata1 = d1;
    for (int idx = 0; idx < 3 * n; idx++) begin
      int k;
      int ph;
      k  = idx / 3;
      ph = idx % 3;
      @(negedge clk);
      check("ep_ack0", ack0, (ph == 2) && !ord[k]);
      check("ep_ack1", ack1, (ph == 2) && ord[k]);
      check("ep_mem_write", mem_write, (ph == 1) && wes[k]);
      if (ph == 1) begin
        check("ep_rd_addr", mem_read_addr, adr[k]);
        if (wes[k]) begin
          check("ep_wr_addr", mem_write_addr, adr[k]);
          check("ep_wr_node", mem_write_node, dat[k]);
        end
      end
      if (ph == 2) begin
        m_rd[ord[k]] = exp_rd[k];
        if (ord[k]) req1 = 1'b0;
        else        req0 = 1'b0;
      end
      check("ep_rdata0", rdata0, m_rd[0]);
      check("ep_rdata1", rdata1, m_rd[1]);
    end
    @(posedge clk); #1;
  endtask

  // Both requesters hold req continuously (reads) for ntx transactions.
  task automatic contend(input int ntx, input logic [4:0] a0, input logic [4:0] a1);
    bit          ord;
    logic [11:0] er;
    ord = 1'b0;
    er  = '0;
    req0 = 1'b1; we0 = 1'b0; addr0 = a0;
    req1 = 1'b1; we1 = 1'b0; addr1 = a1;
    for (int idx = 0; idx < 3 * ntx; idx++) begin
      int ph;
      ph = idx % 3;
      if (ph == 0) begin
        ord = !m_last;
        m_last = ord;
        er = ref_mem[ord ? a1 : a0];
      end
      @(negedge clk);
      check("ct_ack0", ack0, (ph == 2) && !ord);
      check("ct_ack1", ack1, (ph == 2) && ord);
      check("ct_mem_write", mem_write, 0);
      if (ph == 2) m_rd[ord] = er;
      check("ct_rdata0", rdata0, m_rd[0]);
      check("ct_rdata1", rdata1, m_rd[1]);
      if (idx == 3 * ntx - 1) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    salt = 12'($urandom);
    for (int i = 0; i < 32; i++) ref_mem[i] = init_pattern(i, salt);
    mem_clear = 1'b1;
    we0 = 1'b0; addr0 = '0; wdata0 = '0;
    we1 = 1'b0; addr1 = '0; wdata1 = '0;
`ifdef NODE_MEM_ARB_LOCK_EN
    lock0 = 1'b0; lock1 = 1'b0;
`endif

    // Reset then idle.
    do_reset(2);
    mem_clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_ack0", ack0, 0);
      check("rst_ack1", ack1, 0);
      check("rst_rdata0", rdata0, 0);
      check("rst_rdata1", rdata1, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_rd_addr", mem_read_addr, 0);
      check("rst_wr_addr", mem_write_addr, 0);
      check("rst_wr_node", mem_write_node, 0);
    end
    @(posedge clk); #1;

    // Single write then read.
    begin
      logic [11:0] prior;
      prior = ref_mem[3];
      episode(1, 0, 1, 5'd3, 12'hA5C, 0, 5'd0, 12'h0);
      check("wr3_prior", rdata0, prior);
      episode(1, 0, 0, 5'd3, 12'h000, 0, 5'd0, 12'h0);
      check("rd3_value", rdata0, 12'hA5C);
    end

    // Continuous contention from reset: 0,1,0,1.
    do_reset(1);
    contend(4, 5'd3, 5'd10);

    // Write-collision ordering on addr 31.
    episode(0, 1, 0, 5'd0, 12'h0, 1, 5'd31, 12'h0FF);
    episode(1, 0, 1, 5'd31, 12'h123, 0, 5'd0, 12'h0);
    check("coll_rdata0", rdata0, 12'h0FF);
    episode(0, 1, 0, 5'd0, 12'h0, 0, 5'd31, 12'h0);
    check("coll_read31", rdata1, 12'h123);

    // Same-address writes from both sides in one contention episode.
    episode(1, 1, 1, 5'd12, 12'h3C3, 1, 5'd12, 12'hC3C);

    // Reset during the ACCESS cycle of a write.
    episode(1, 0, 1, 5'd7, 12'h111, 0, 5'd0, 12'h0);
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd7; wdata0 = 12'h777;
    @(posedge clk); #1;
    reset = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    check("midrst_mem_write", mem_write, 0);
    check("midrst_ack0", ack0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_last = 1'b1; m_rd[0] = '0; m_rd[1] = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_ack0", ack0, 0);
      check("midrst_rdata0", rdata0, 0);
    end
    @(posedge clk); #1;
    episode(1, 0, 0, 5'd7, 12'h0, 0, 5'd0, 12'h0);
    check("midrst_read7", rdata0, 12'h111);

    // Randomized episodes checked against the model.
    for (int t = 0; t < 30; t++) begin
      bit u0, u1;
      logic [4:0] a0, a1;
      u0 = 1'($urandom);
      u1 = 1'($urandom);
      if (!u0 && !u1) u0 = 1'b1;
      a0 = (t % 2 == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      a1 = (t % 2 == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      episode(u0, u1, 1'($urandom), a0, 12'($urandom), 1'($urandom), a1, 12'($urandom));
    end

`ifdef NODE_MEM_ARB_LOCK_EN
    // Lock: requester 0 locks for two transactions, then unlocks on the third.
    begin : lock_test
      int n0;
      bit got1;
      n0 = 0;
      got1 = 1'b0;
      do_reset(2);
      req1 = 1'b1; we1 = 1'b0; addr1 = 5'd9;  lock1 = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 5'd8;  lock0 = 1'b1;
      for (int idx = 0; idx < 15 && !got1; idx++) begin
        @(negedge clk);
        check("lock_no_overlap", ack0 & ack1, 0);
        if (ack1) begin
          got1 = 1'b1;
          req1 = 1'b0;
          check("lock_owner_served", n0, 3);
        end else if (ack0) begin
          n0++;
          if (n0 == 2) lock0 = 1'b0;
          if (n0 == 3) req0 = 1'b0;
        end
      end
      check("lock_req1_served", got1, 1);
      @(posedge clk); #1;
      do_reset(1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/node_mem_arbiter.md
Name: node_mem_arbiter

Overview:
- Shares the single read/write port of the 32-entry x 12-bit node memory between two requesters (tree builder and tree walker).
- Each requester uses a req/ack handshake for one read or write transaction.
- Round-robin arbitration. Every transaction returns the node value that was present before any write.
- Sits between the requesters and the node memory. The arbiter drives all memory port inputs.

Parameters:
NODE_W, 12, node word width
ADDR_W, 5, node address width (32 nodes)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req0  in  1  requester 0 transaction request
we0  in  1  requester 0: 1 = write, 0 = read
addr0  in  ADDR_W  requester 0 node address
wdata0  in  NODE_W  requester 0 write data
ack0  out  1  requester 0 completion pulse
rdata0  out  NODE_W  requester 0 returned node (prior contents)
req1, we1, addr1, wdata1, ack1, rdata1  same as requester 0, for requester 1
mem_read_addr  out  ADDR_W  memory read address
mem_read_node  in  NODE_W  memory combinational read data
mem_write_addr  out  ADDR_W  memory write address
mem_write_node  out  NODE_W  memory write data
mem_write  out  1  memory write enable (takes effect at the clock edge)

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset forces IDLE from any state, mid-transaction included. The in-flight transaction is abandoned: no ack, no write.
- Reset values:
  - ack0 = ack1 = 0, rdata0 = rdata1 = 0.
  - mem_write = 0, mem_read_addr = mem_write_addr = 0, mem_write_node = 0.
  - last_grant = 1, so requester 0 wins the first contention.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant that requester.
  - Both reqs: grant the requester that is not last_grant.
  - On grant: latch we, addr and wdata into internal registers, set last_grant, go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_read_addr = mem_write_addr = latched addr; mem_write_node = latched wdata.
  - mem_write = latched we.
  - At the end of the cycle, capture mem_read_node into the granted rdata register. Because the write commits at that same edge, a write returns the old contents.
  - Go to RESP.
- RESP (one cycle): ack of the granted requester = 1 and its rdata is valid. Then go to IDLE.
- rdata holds its value until that requester's next ack. The other requester's rdata is unaffected.
- Latency: req sampled in IDLE at cycle N, memory accessed in cycle N+1, ack high in cycle N+2. Throughput: one transaction per 3 cycles.
- Handshake: the requester holds req, we, addr and wdata until ack. Changes after grant are ignored (already latched).
  - req dropped after grant: the transaction still completes and ack still pulses.
  - req still high in the cycle after ack: treated as a new request. It is arbitrated with the updated last_grant, so alternation is guaranteed under continuous contention.
- mem_write is high only in ACCESS, never in IDLE or RESP, and never in a cycle where reset is high.
- Two requesters writing the same address back to back: the second one's rdata equals the first one's wdata.

Optional Feature:
NODE_MEM_ARB_LOCK_EN
- Defined:
  - Adds input ports lock0 and lock1 (1 bit each), sampled together with the request at grant.
  - If the granted requester's lock is high at grant, the arbiter enters locked mode after RESP.
  - In locked mode, IDLE grants only that requester; the other requester's req waits indefinitely.
  - Locked mode ends when a transaction from the locking requester is granted with lock low, or on reset.
  - Lock from the non-owner is ignored while locked.
- Undefined: the lock ports are absent and arbitration is pure round-robin.

Test Plan:
- Reset then idle: reset high 2 cycles, then reset low with no reqs for 5 cycles -> all outputs 0, mem_write never 1.
- Single write then read: req0 write addr 3 wdata 12'hA5C -> ack0 at cycle N+2, rdata0 = prior contents. Then req0 read addr 3 -> rdata0 = 12'hA5C.
- Contention: req0 and req1 asserted together, held continuously for 4 transactions -> grant order 0,1,0,1, and the acks never overlap.
- Write-collision ordering: req1 write addr 31 wdata 12'h0FF, then req0 write addr 31 wdata 12'h123 -> rdata0 = 12'h0FF, and a subsequent read of addr 31 = 12'h123.
- Reset mid-op: assert reset in the ACCESS cycle of a write of 12'h777 to addr 7 -> no ack, mem_write = 0 that cycle, and a later read of addr 7 does not return 12'h777 (assuming the prior value differs).
- Lock (NODE_MEM_ARB_LOCK_EN): req0 with lock0 = 1 for 2 transactions, req1 asserted throughout -> requester 0 is served 3 times (last transaction with lock0 = 0) before requester 1's first ack.
